// File: rtl/lbp_engine_param.sv
// Parametrised 3x3 Local Binary Pattern engine; reuses two window columns per horizontal step.
// Optional macro LBP_BORDER_ZERO_EN: border pixels are also written, with code 8'h00.
module lbp_engine_param #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

  localparam logic [31:0] W32 = 32'(IMG_W);

  state_t        state_q, state_d;
  logic [AW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    fcol_q, fcol_d, frow_q, frow_d;
  logic          capValid_q;
  logic [1:0]    capCol_q, capRow_q;
  logic [DW-1:0] win_q [3][3];
  logic          shiftWin;
  logic [AW-1:0] nx, ny;
  logic          lastPix;
  logic [7:0]    code;
`ifdef LBP_BORDER_ZERO_EN
  logic          nextBorder, curBorder;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    fcol_d   = fcol_q;
    frow_d   = frow_q;
    shiftWin = 1'b0;
    nx       = x_q;
    ny       = y_q;
    lastPix  = 1'b0;
`ifdef LBP_BORDER_ZERO_EN
    nextBorder = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (gray_ready) begin
`ifdef LBP_BORDER_ZERO_EN
          x_d     = '0;
          y_d     = '0;
          state_d = WRITE;
`else
          x_d     = AW'(1);
          y_d     = AW'(1);
          fcol_d  = 2'd0;
          frow_d  = 2'd0;
          state_d = FETCH;
`endif
        end
      end
      // Fetch order walks each column top-to-bottom; fcol starts at 2 when only the new column is needed.
      FETCH: begin
        if (frow_q == 2'd2) begin
          frow_d = 2'd0;
          if (fcol_q == 2'd2) state_d = WAIT;
          else                fcol_d  = fcol_q + 2'd1;
        end else begin
          frow_d = frow_q + 2'd1;
        end
      end
      WAIT: state_d = WRITE;
      WRITE: begin
`ifdef LBP_BORDER_ZERO_EN
        lastPix = (x_q == AW'(IMG_W - 1)) && (y_q == AW'(IMG_H - 1));
        if (x_q == AW'(IMG_W - 1)) begin
          nx = '0;
          ny = y_q + AW'(1);
        end else begin
          nx = x_q + AW'(1);
        end
        nextBorder = (nx == '0) || (nx == AW'(IMG_W - 1)) ||
                     (ny == '0) || (ny == AW'(IMG_H - 1));
`else
        if (x_q == AW'(IMG_W - 2)) begin
          nx = AW'(1);
          ny = y_q + AW'(1);
        end else begin
          nx = x_q + AW'(1);
        end
        lastPix = (ny == AW'(IMG_H - 1));
`endif
        x_d = nx;
        y_d = ny;
        if (lastPix) begin
          state_d = DONE;
`ifdef LBP_BORDER_ZERO_EN
        end else if (nextBorder) begin
          state_d = WRITE;
`endif
        end else begin
          state_d  = FETCH;
          frow_d   = 2'd0;
          fcol_d   = (nx == AW'(1)) ? 2'd0 : 2'd2;
          shiftWin = (nx != AW'(1));
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    code    = '0;
    code[0] = win_q[0][0] >= win_q[1][1];
    code[1] = win_q[1][0] >= win_q[1][1];
    code[2] = win_q[2][0] >= win_q[1][1];
    code[3] = win_q[0][1] >= win_q[1][1];
    code[4] = win_q[2][1] >= win_q[1][1];
    code[5] = win_q[0][2] >= win_q[1][1];
    code[6] = win_q[1][2] >= win_q[1][1];
    code[7] = win_q[2][2] >= win_q[1][1];
  end

`ifdef LBP_BORDER_ZERO_EN
  assign curBorder = (x_q == '0) || (x_q == AW'(IMG_W - 1)) ||
                     (y_q == '0) || (y_q == AW'(IMG_H - 1));
`endif

  always_comb begin
    gray_req  = (state_q == FETCH);
    gray_addr = '0;
    lbp_valid = (state_q == WRITE);
    lbp_addr  = '0;
    lbp_data  = '0;
    finish    = (state_q == DONE);
    if (state_q == FETCH)
      gray_addr = AW'((32'(y_q) + 32'(frow_q) - 32'd1) * W32 + 32'(x_q) + 32'(fcol_q) - 32'd1);
    if (state_q == WRITE) begin
      lbp_addr = AW'(32'(y_q) * W32 + 32'(x_q));
`ifdef LBP_BORDER_ZERO_EN
      lbp_data = curBorder ? 8'h00 : code;
`else
      lbp_data = code;
`endif
    end
  end

  // Read data returns one cycle after its address, so the slot it belongs to is delayed alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= AW'(1);
      y_q        <= AW'(1);
      fcol_q     <= 2'd0;
      frow_q     <= 2'd0;
      capValid_q <= 1'b0;
      capCol_q   <= 2'd0;
      capRow_q   <= 2'd0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win_q[c][r] <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fcol_q     <= fcol_d;
      frow_q     <= frow_d;
      capValid_q <= (state_q == FETCH);
      capCol_q   <= fcol_q;
      capRow_q   <= frow_q;
      if (shiftWin) begin
        for (int r = 0; r < 3; r++) begin
          win_q[0][r] <= win_q[1][r];
          win_q[1][r] <= win_q[2][r];
        end
      end
      if (capValid_q)
        win_q[capCol_q][capRow_q] <= gray_data;
    end
  end

endmodule

// File: tb/tb_lbp_engine_param.sv
// Scoreboard bench for lbp_engine_param on a 4x4 image: directed images, a mid-run reset and random images.
module tb_lbp_engine_param;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 8;
   localparam int AW = 4;

   typedef struct {
      int addr;
      int data;
      int idx;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [DW-1:0] gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [7:0]    lbp_data;
   logic          finish;

   logic [DW-1:0] img [W*H];
   exp_t          expQ [$];
   int            checks;
   int            errors;
   int            cycleCnt;
   int            startCnt;
   int            expFinishIdx;
   bit            finishSeen;

   lbp_engine_param #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
      .clk(clk),
      .reset(reset),
      .gray_ready(gray_ready),
      .gray_req(gray_req),
      .gray_addr(gray_addr),
      .gray_data(gray_data),
      .lbp_valid(lbp_valid),
      .lbp_addr(lbp_addr),
      .lbp_data(lbp_data),
      .finish(finish)
   );

   // Free-running clock and a cycle counter used to time each write relative to the start edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCnt++;

   // Gray memory with one cycle of read latency
   always @(posedge clk) gray_data <= img[gray_addr];

   // Reference LBP code from the neighbourhood rule: taps in raster order, bit set when tap >= centre
   function automatic logic [7:0] lbpRef(input int x, input int y);
      logic [7:0] code;
      int i;
      int c;
      code = '0;
      i = 0;
      c = int'(img[y*W + x]);
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
               code[i] = (int'(img[(y+dy)*W + x + dx]) >= c);
               i++;
            end
         end
      end
      return code;
   endfunction

   // Expected write list in raster order, with the cycle index at which each write should appear
   task automatic buildExpected();
      int t;
      bit border;
      exp_t e;
      t = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            border = (x == 0) || (y == 0) || (x == W-1) || (y == H-1);
            if (border) begin
`ifdef LBP_BORDER_ZERO_EN
               t += 1;
               e.addr = y*W + x; e.data = 0; e.idx = t;
               expQ.push_back(e);
`endif
            end else begin
               t += (x == 1) ? 11 : 5;
               e.addr = y*W + x; e.data = int'(lbpRef(x, y)); e.idx = t;
               expQ.push_back(e);
            end
         end
      end
      expFinishIdx = t + 1;
   endtask

   task automatic checkOutput(input string name);
      logic [AW*2+11:0] outs;
      outs = {gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("[TB] FAIL %s outputs=%h required=0", name, outs);
      end
   endtask

   // One image run: mode selects the fill, abortAddr>=0 pulls reset during the fetch of that address
   task automatic applyStimulus(input int mode, input int abortAddr);
      bit found;
      reset = 1'b0;
      gray_ready = 1'b0;
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state");
      for (int a = 0; a < W*H; a++) begin
         case (mode)
            0: img[a] = 8'h40;
            1: img[a] = (a == 5) ? 8'hFF : 8'h00;
            2: img[a] = DW'(a);
            3: img[a] = DW'($urandom_range(0, 3));
            default: img[a] = DW'($urandom);
         endcase
      end
      buildExpected();
      finishSeen = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      gray_ready = 1'b1;
      startCnt = cycleCnt;
      @(posedge clk);
      #1;
      gray_ready = 1'($urandom_range(0, 1));
      if (abortAddr >= 0) begin
         found = 1'b0;
         for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (gray_req && int'(gray_addr) == abortAddr) found = 1'b1;
         end
         checks++;
         if (!found) begin
            errors++;
            $display("[TB] FAIL abort_fetch got=none required=addr%0d", abortAddr);
         end
         reset = 1'b0;
         #1;
         checkOutput("abort_immediate");
         repeat (3) @(posedge clk);
         #1;
         checkOutput("abort_held");
         expQ.delete();
         return;
      end
      for (int i = 0; i < 2000 && !finish; i++) @(posedge clk);
      repeat (2) @(negedge clk);
      checks++;
      if (!finish) begin
         errors++;
         $display("[TB] FAIL finish_timeout got=0 required=1");
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_writes got=%0d_left required=0", expQ.size());
      end
   endtask

   // Monitor: pops the scoreboard on each write strobe and polices idle outputs
   always @(negedge clk) begin
      exp_t e;
      int idx;
      idx = cycleCnt - startCnt;
      if (reset) begin
         if (lbp_valid) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_write addr=%0d data=%h required=none", lbp_addr, lbp_data);
            end else begin
               e = expQ.pop_front();
               if (int'(lbp_addr) != e.addr || int'(lbp_data) != e.data) begin
                  errors++;
                  $display("[TB] FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                           lbp_addr, lbp_data, e.addr, e.data);
               end
               checks++;
               if (idx != e.idx) begin
                  errors++;
                  $display("[TB] FAIL write_cycle addr=%0d got=%0d required=%0d", e.addr, idx, e.idx);
               end
            end
         end else begin
            checks++;
            if (lbp_data !== 8'h00) begin
               errors++;
               $display("[TB] FAIL idle_data got=%h required=00", lbp_data);
            end
         end
         if (finish || lbp_valid) begin
            checks++;
            if (gray_req !== 1'b0) begin
               errors++;
               $display("[TB] FAIL gray_req_outside_fetch got=1 required=0");
            end
         end
         if (finish && !finishSeen) begin
            finishSeen = 1'b1;
            checks++;
            if (idx != expFinishIdx) begin
               errors++;
               $display("[TB] FAIL finish_cycle got=%0d required=%0d", idx, expFinishIdx);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      cycleCnt = 0;
      startCnt = 0;
      expFinishIdx = 0;
      finishSeen = 1'b0;
      reset = 1'b0;
      gray_ready = 1'b0;
      for (int a = 0; a < W*H; a++) img[a] = '0;
      applyStimulus(0, -1);
      applyStimulus(1, -1);
      applyStimulus(2, -1);
      applyStimulus(0, 6);
      applyStimulus(0, -1);
      for (int r = 0; r < 40; r++) applyStimulus(3 + (r % 2), -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
